// File: rtl/csr_hpm_bank.sv
// Bank of machine-mode hardware performance counters with their event selectors, mcountinhibit,
// mcounteren and user-mode aliases. Define HPM_OVF_IRQ_EN to add sticky overflow flags and ovf_irq.
module csr_hpm_bank #(
   parameter int NUM_COUNTERS = 4,
   parameter int NUM_EVENTS   = 8,
   parameter int CNT_W        = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            cur_priv,
   input  logic                  csr_en,
   input  logic [1:0]            csr_op,
   input  logic [11:0]           csr_addr,
   input  logic [63:0]           csr_wdata,
   output logic [63:0]           csr_rdata,
   output logic                  csr_trap_ill,
   output logic                  hit,
   input  logic [NUM_EVENTS-1:0] event_in,
   output logic                  ovf_irq
);

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_SET   = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;
   localparam logic [1:0] PRIV_U   = 2'd0;
   localparam logic [1:0] PRIV_M   = 2'd3;

   logic [CNT_W-1:0]        cnt_q [NUM_COUNTERS];
   logic [CNT_W-1:0]        cnt_d [NUM_COUNTERS];
   logic [7:0]              sel_q [NUM_COUNTERS];
   logic [7:0]              sel_d [NUM_COUNTERS];
   logic [NUM_COUNTERS-1:0] inh_q, inh_d;
   logic [NUM_COUNTERS-1:0] cen_q, cen_d;
`ifdef HPM_OVF_IRQ_EN
   logic [NUM_COUNTERS-1:0] of_q, of_d;
   logic                    ovf_irq_q, ovf_irq_d;
`endif

   logic [4:0]              idx;
   logic [4:0]              ci;
   logic                    impl;
   logic                    is_cen, is_inh, is_evt, is_mcnt, is_ucnt;
   logic [31:0]             cen_full, inh_full;
   logic [CNT_W-1:0]        cur_cnt;
   logic [7:0]              cur_sel;
   logic                    cur_of;
   logic [63:0]             rdata;
   logic [63:0]             wval;
   logic                    we;
   logic [NUM_COUNTERS-1:0] inc;
   logic [NUM_COUNTERS-1:0] sel_hit;

   // Selector values 0 and above NUM_EVENTS match no event line.
   function automatic logic evt_fires(input logic [7:0] sel, input logic [NUM_EVENTS-1:0] ev);
      logic f;
      f = 1'b0;
      for (int j = 0; j < NUM_EVENTS; j++) begin
         f = f | ((sel == 8'(j + 1)) & ev[j]);
      end
      return f;
   endfunction

   assign idx      = csr_addr[4:0];
   assign ci       = idx - 5'd3;
   assign impl     = (idx >= 5'd3) && ({1'b0, idx} < 6'(3 + NUM_COUNTERS));
   assign is_cen   = (csr_addr == 12'h306);
   assign is_inh   = (csr_addr == 12'h320);
   assign is_evt   = (csr_addr[11:5] == 7'h19) && (idx >= 5'd3);
   assign is_mcnt  = (csr_addr[11:5] == 7'h58) && (idx >= 5'd3);
   assign is_ucnt  = (csr_addr[11:5] == 7'h60) && (idx >= 5'd3);
   assign hit      = is_cen | is_inh | is_evt | is_mcnt | is_ucnt;
   assign cen_full = 32'({cen_q, 3'b000});
   assign inh_full = 32'({inh_q, 3'b000});

   // Pick the addressed counter slot; unimplemented slots read as zero.
   always_comb begin
      cur_cnt = {CNT_W{1'b0}};
      cur_sel = 8'd0;
      cur_of  = 1'b0;
      for (int k = 0; k < NUM_COUNTERS; k++) begin
         sel_hit[k] = impl && (ci == 5'(k));
         if (sel_hit[k]) begin
            cur_cnt = cnt_q[k];
            cur_sel = sel_q[k];
`ifdef HPM_OVF_IRQ_EN
            cur_of  = of_q[k];
`else
            cur_of  = 1'b0;
`endif
         end else begin
            cur_cnt = cur_cnt;
         end
      end
   end

   // Read mux.
   always_comb begin
      rdata = 64'd0;
      if (is_cen) begin
         rdata = {32'd0, cen_full};
      end else if (is_inh) begin
         rdata = {32'd0, inh_full};
      end else if (is_evt) begin
         rdata = {cur_of, 55'd0, cur_sel};
      end else if (is_mcnt || is_ucnt) begin
         rdata = 64'(cur_cnt);
      end else begin
         rdata = 64'd0;
      end
   end

   assign csr_rdata    = rdata;
   assign csr_trap_ill = csr_en && hit &&
                         (((cur_priv != PRIV_M) && !is_ucnt) ||
                          ((csr_op != OP_READ) && (csr_addr[11:10] == 2'b11)) ||
                          ((cur_priv == PRIV_U) && is_ucnt && !cen_full[idx]));
   assign we           = csr_en && hit && !csr_trap_ill && (csr_op != OP_READ);

   // Read-modify-write operand.
   always_comb begin
      wval = csr_wdata;
      case (csr_op)
         OP_WRITE: wval = csr_wdata;
         OP_SET:   wval = rdata | csr_wdata;
         OP_CLEAR: wval = rdata & ~csr_wdata;
         default:  wval = csr_wdata;
      endcase
   end

   // Increment enables use the selector and inhibit values held before this edge.
   always_comb begin
      for (int k = 0; k < NUM_COUNTERS; k++) begin
         inc[k] = !inh_q[k] && evt_fires(sel_q[k], event_in);
      end
   end

   // Next state: a CSR write to a counter or selector overrides the same-cycle hardware update.
   always_comb begin
      inh_d = (we && is_inh) ? wval[3 +: NUM_COUNTERS] : inh_q;
      cen_d = (we && is_cen) ? wval[3 +: NUM_COUNTERS] : cen_q;
      for (int k = 0; k < NUM_COUNTERS; k++) begin
         cnt_d[k] = (we && is_mcnt && sel_hit[k]) ? wval[CNT_W-1:0]
                                                  : cnt_q[k] + {{(CNT_W-1){1'b0}}, inc[k]};
         sel_d[k] = (we && is_evt && sel_hit[k]) ? wval[7:0] : sel_q[k];
`ifdef HPM_OVF_IRQ_EN
         if (we && is_evt && sel_hit[k]) begin
            of_d[k] = wval[63];
         end else if (inc[k] && (&cnt_q[k])) begin
            of_d[k] = 1'b1;
         end else begin
            of_d[k] = of_q[k];
         end
`endif
      end
`ifdef HPM_OVF_IRQ_EN
      ovf_irq_d = |of_d;
`endif
   end

   // State registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < NUM_COUNTERS; k++) begin
            cnt_q[k] <= {CNT_W{1'b0}};
            sel_q[k] <= 8'd0;
         end
         inh_q <= {NUM_COUNTERS{1'b0}};
         cen_q <= {NUM_COUNTERS{1'b0}};
`ifdef HPM_OVF_IRQ_EN
         of_q      <= {NUM_COUNTERS{1'b0}};
         ovf_irq_q <= 1'b0;
`endif
      end else begin
         cnt_q <= cnt_d;
         sel_q <= sel_d;
         inh_q <= inh_d;
         cen_q <= cen_d;
`ifdef HPM_OVF_IRQ_EN
         of_q      <= of_d;
         ovf_irq_q <= ovf_irq_d;
`endif
      end
   end

`ifdef HPM_OVF_IRQ_EN
   assign ovf_irq = ovf_irq_q;
`else
   assign ovf_irq = 1'b0;
`endif

endmodule

// File: tb/tb_csr_hpm_bank.sv
// Self-checking bench for csr_hpm_bank (4 counters, 8 events, 32-bit counters):
// a vector table for CSR decode/access rules, then hand sequences for counting corner cases.
module tb_csr_hpm_bank;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  cur_priv;
   logic        csr_en;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [63:0] csr_wdata;
   logic [63:0] csr_rdata;
   logic        csr_trap_ill;
   logic        hit;
   logic [7:0]  event_in;
   logic        ovf_irq;

   int total = 0;
   int bad   = 0;

`ifdef HPM_OVF_IRQ_EN
   localparam logic IRQ = 1'b1;
`else
   localparam logic IRQ = 1'b0;
`endif

   localparam logic [1:0] R = 2'd0, W = 2'd1, S = 2'd2, C = 2'd3;
   localparam logic [1:0] PU = 2'd0, PS = 2'd1, PM = 2'd3;

   typedef struct {
      string       name;
      logic [63:0] rdata;
      logic        trap;
      logic        hit;
   } exp_t;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [11:0] addr;
      logic [63:0] wdata;
      logic [1:0]  priv;
      logic [63:0] rdata;
      logic        trap;
      logic        hit;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[$];

   csr_hpm_bank #(.NUM_COUNTERS(4), .NUM_EVENTS(8), .CNT_W(32)) dut (
      .clock(clock), .reset(reset), .cur_priv(cur_priv), .csr_en(csr_en), .csr_op(csr_op),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
      .csr_trap_ill(csr_trap_ill), .hit(hit), .event_in(event_in), .ovf_irq(ovf_irq)
   );

   always #5 clock = ~clock;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One CSR access cycle: expected result queued at drive time, compared at the falling edge.
   task automatic csr_access(input string name, input logic [1:0] op, input logic [11:0] addr,
                             input logic [63:0] wd, input logic [1:0] priv,
                             input logic [63:0] exp_rd, input logic exp_trap, input logic exp_hit);
      exp_t e;
      csr_en    = 1'b1;
      csr_op    = op;
      csr_addr  = addr;
      csr_wdata = wd;
      cur_priv  = priv;
      e.name = name; e.rdata = exp_rd; e.trap = exp_trap; e.hit = exp_hit;
      sb_q.push_back(e);
      @(negedge clock);
      e = sb_q.pop_front();
      check64({e.name, " rdata"}, csr_rdata, e.rdata);
      check64({e.name, " trap"}, 64'(csr_trap_ill), 64'(e.trap));
      check64({e.name, " hit"}, 64'(hit), 64'(e.hit));
      @(posedge clock);
      #1;
      csr_en    = 1'b0;
      csr_op    = R;
      csr_addr  = 12'h000;
      csr_wdata = 64'd0;
      cur_priv  = PM;
   endtask

   task automatic rd(input string name, input logic [11:0] addr, input logic [63:0] exp_rd);
      csr_access(name, R, addr, 64'd0, PM, exp_rd, 1'b0, 1'b1);
   endtask

   task automatic wr(input string name, input logic [1:0] op, input logic [11:0] addr,
                     input logic [63:0] wd, input logic [63:0] old_rd);
      csr_access(name, op, addr, wd, PM, old_rd, 1'b0, 1'b1);
   endtask

   task automatic pulse(input logic [7:0] ev, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         event_in = ev;
         @(posedge clock);
         #1;
         event_in = 8'd0;
      end
   endtask

   task automatic check_irq(input string name, input logic exp);
      @(negedge clock);
      check64(name, 64'(ovf_irq), 64'(exp));
      @(posedge clock);
      #1;
   endtask

   function automatic vec_t mk(input string name, input logic [1:0] op, input logic [11:0] addr,
                               input logic [63:0] wd, input logic [1:0] priv,
                               input logic [63:0] rdv, input logic tr, input logic h);
      vec_t v;
      v.name = name; v.op = op; v.addr = addr; v.wdata = wd; v.priv = priv;
      v.rdata = rdv; v.trap = tr; v.hit = h;
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs.push_back(mk("rst cnt3",      R, 12'hB03, 64'd0, PM, 64'd0, 1'b0, 1'b1));
      vecs.push_back(mk("rst evt3",      R, 12'h323, 64'd0, PM, 64'd0, 1'b0, 1'b1));
      vecs.push_back(mk("rst inhibit",   R, 12'h320, 64'd0, PM, 64'd0, 1'b0, 1'b1));
      vecs.push_back(mk("rst counteren", R, 12'h306, 64'd0, PM, 64'd0, 1'b0, 1'b1));
      vecs.push_back(mk("miss 300",      R, 12'h300, 64'd0, PM, 64'd0, 1'b0, 1'b0));
      vecs.push_back(mk("unimpl B1F",    R, 12'hB1F, 64'd0, PM, 64'd0, 1'b0, 1'b1));
      vecs.push_back(mk("wr inh ones",   W, 12'h320, 64'hFFFF_FFFF_FFFF_FFFF, PM, 64'd0, 1'b0, 1'b1));
      vecs.push_back(mk("rd inh mask",   R, 12'h320, 64'd0, PM, 64'h78, 1'b0, 1'b1));
      vecs.push_back(mk("clr inh",       C, 12'h320, 64'h78, PM, 64'h78, 1'b0, 1'b1));
      vecs.push_back(mk("rd inh 0",      R, 12'h320, 64'd0, PM, 64'd0, 1'b0, 1'b1));
      vecs.push_back(mk("wr evt3",       W, 12'h323, 64'hFF05, PM, 64'd0, 1'b0, 1'b1));
      vecs.push_back(mk("rd evt3",       R, 12'h323, 64'd0, PM, 64'h05, 1'b0, 1'b1));
      vecs.push_back(mk("wr cnt4 wide",  W, 12'hB04, 64'h1_2345_6789, PM, 64'd0, 1'b0, 1'b1));
      vecs.push_back(mk("rd cnt4 trunc", R, 12'hB04, 64'd0, PM, 64'h2345_6789, 1'b0, 1'b1));
      vecs.push_back(mk("M rd C04",      R, 12'hC04, 64'd0, PM, 64'h2345_6789, 1'b0, 1'b1));
      vecs.push_back(mk("M wr C04",      W, 12'hC04, 64'd0, PM, 64'h2345_6789, 1'b1, 1'b1));
      vecs.push_back(mk("U rd B04",      R, 12'hB04, 64'd0, PU, 64'h2345_6789, 1'b1, 1'b1));
      vecs.push_back(mk("U rd C04 cen0", R, 12'hC04, 64'd0, PU, 64'h2345_6789, 1'b1, 1'b1));
      vecs.push_back(mk("wr cen bit4",   W, 12'h306, 64'h10, PM, 64'd0, 1'b0, 1'b1));
      vecs.push_back(mk("U rd C04 cen1", R, 12'hC04, 64'd0, PU, 64'h2345_6789, 1'b0, 1'b1));
      vecs.push_back(mk("U rd C03 cen0", R, 12'hC03, 64'd0, PU, 64'd0, 1'b1, 1'b1));
      vecs.push_back(mk("U rd C1F",      R, 12'hC1F, 64'd0, PU, 64'd0, 1'b1, 1'b1));
      vecs.push_back(mk("set cen",       S, 12'h306, 64'hFFFF_FFFF, PM, 64'h10, 1'b0, 1'b1));
      vecs.push_back(mk("rd cen mask",   R, 12'h306, 64'd0, PM, 64'h78, 1'b0, 1'b1));
      vecs.push_back(mk("rd evt 33F",    R, 12'h33F, 64'd0, PM, 64'd0, 1'b0, 1'b1));
      vecs.push_back(mk("wr evt 33F",    W, 12'h33F, 64'hFF, PM, 64'd0, 1'b0, 1'b1));
      vecs.push_back(mk("rd evt 33F wi", R, 12'h33F, 64'd0, PM, 64'd0, 1'b0, 1'b1));
      vecs.push_back(mk("miss 322",      R, 12'h322, 64'd0, PM, 64'd0, 1'b0, 1'b0));
      vecs.push_back(mk("miss B02",      R, 12'hB02, 64'd0, PM, 64'd0, 1'b0, 1'b0));
      vecs.push_back(mk("U wr inh",      W, 12'h320, 64'd0, PU, 64'd0, 1'b1, 1'b1));
      vecs.push_back(mk("S rd inh",      R, 12'h320, 64'd0, PS, 64'd0, 1'b1, 1'b1));

      reset = 1'b1; cur_priv = PM; csr_en = 1'b0; csr_op = R; csr_addr = 12'h000;
      csr_wdata = 64'd0; event_in = 8'd0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      check_irq("rst irq", 1'b0);

      foreach (vecs[i]) begin
         csr_access(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].priv,
                    vecs[i].rdata, vecs[i].trap, vecs[i].hit);
      end

      // Counting and inhibit
      wr("sel3=2", W, 12'h323, 64'd2, 64'd5);
      pulse(8'h02, 5);
      rd("count 5", 12'hB03, 64'd5);
      wr("inhibit3", S, 12'h320, 64'h8, 64'd0);
      pulse(8'h02, 5);
      rd("inhibited 5", 12'hB03, 64'd5);
      wr("uninhibit3", C, 12'h320, 64'h8, 64'h8);

      // Write beats same-cycle increment; inhibit applies from the next cycle
      event_in = 8'h02;
      wr("wr cnt3 w/ev", W, 12'hB03, 64'd7, 64'd5);
      event_in = 8'h00;
      rd("write wins", 12'hB03, 64'd7);
      event_in = 8'h02;
      wr("inh w/ev", S, 12'h320, 64'h8, 64'd0);
      event_in = 8'h00;
      rd("inh late", 12'hB03, 64'd8);
      rd("inh set", 12'h320, 64'h8);
      pulse(8'h02, 1);
      rd("inh holds", 12'hB03, 64'd8);
      wr("uninhibit3b", C, 12'h320, 64'h8, 64'h8);
      csr_access("U rd C03 cen1", R, 12'hC03, 64'd0, PU, 64'd8, 1'b0, 1'b1);

      // Out-of-range selectors never count
      wr("sel3=0", W, 12'h323, 64'd0, 64'd2);
      pulse(8'hFF, 3);
      rd("sel0 holds", 12'hB03, 64'd8);
      rd("cnt4 sel0", 12'hB04, 64'h2345_6789);
      wr("sel3=9", W, 12'h323, 64'd9, 64'd0);
      pulse(8'hFF, 3);
      rd("sel9 holds", 12'hB03, 64'd8);
      rd("sel9 stored", 12'h323, 64'd9);
      wr("sel3=8", W, 12'h323, 64'd8, 64'd9);
      pulse(8'h80, 1);
      rd("sel8 counts", 12'hB03, 64'd9);

      // Wrap and overflow flag
      wr("cnt3 max", W, 12'hB03, 64'hFFFF_FFFF, 64'd9);
      check_irq("pre-wrap irq", 1'b0);
      pulse(8'h80, 1);
      check_irq("wrap irq", IRQ);
      rd("wrapped", 12'hB03, 64'd0);
      rd("OF set", 12'h323, {IRQ, 55'd0, 8'd8});
      wr("clr OF", C, 12'h323, 64'h8000_0000_0000_0000, {IRQ, 55'd0, 8'd8});
      check_irq("irq cleared", 1'b0);
      rd("OF clear", 12'h323, 64'd8);
      wr("cnt3 max b", W, 12'hB03, 64'hFFFF_FFFF, 64'd0);
      event_in = 8'h80;
      wr("evt wr w/wrap", W, 12'h323, 64'd8, 64'd8);
      event_in = 8'h00;
      check_irq("evt wr wins irq", 1'b0);
      rd("evt wr wins OF", 12'h323, 64'd8);
      rd("wrapped b", 12'hB03, 64'd0);

      // Reset during counting
      pulse(8'h80, 2);
      rd("pre-reset cnt", 12'hB03, 64'd2);
      reset = 1'b1;
      event_in = 8'h80;
      @(posedge clock);
      #1;
      reset = 1'b0;
      event_in = 8'h00;
      rd("post-rst cnt3", 12'hB03, 64'd0);
      rd("post-rst cnt4", 12'hB04, 64'd0);
      rd("post-rst evt3", 12'h323, 64'd0);
      rd("post-rst cen", 12'h306, 64'd0);
      check_irq("post-rst irq", 1'b0);

      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard: got %0d left expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
